// File: rtl/req_rr_arb.sv
// req_rr_arb: round-robin level req/gnt arbiter with one-cycle release gap; ARB_FAIR_EN enables preemption of long holders
module req_rr_arb #(
  parameter int N        = 4,
  parameter int IDW      = 2,
  parameter int MAX_HOLD = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req,
  output logic [N-1:0]   gnt,
  output logic           gnt_valid,
  output logic [IDW-1:0] gnt_id,
  output logic           busy,
  output logic           preempt
);
  typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;
  state_t         state_q, state_d;
  logic [IDW-1:0] ptr_q, ptr_d, id_q, id_d, win, idx;
  logic [N-1:0]   gnt_q, gnt_d;
  logic           found, own_req;
`ifdef ARB_FAIR_EN
  localparam int HW = $clog2(MAX_HOLD);
  localparam logic [HW-1:0] HMAX = HW'(MAX_HOLD - 1);
  logic [HW-1:0]  hold_q, hold_d;
  logic           preempt_q, preempt_d;
`endif
  assign own_req   = req[id_q];
  assign gnt       = gnt_q;
  assign gnt_valid = |gnt_q;
  assign gnt_id    = id_q;
  assign busy      = state_q != IDLE;
`ifdef ARB_FAIR_EN
  assign preempt   = preempt_q;
`else
  assign preempt   = 1'b0;
`endif
  // first requester at or after ptr, wrapping modulo N
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int k = 0; k < N; k++) begin
      idx = IDW'((int'(ptr_q) + k) % N);
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end
  // next-state: grant in IDLE, hold or release in GRANT, single gap cycle in RELEASE
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    id_d    = id_q;
`ifdef ARB_FAIR_EN
    hold_d    = hold_q;
    preempt_d = 1'b0;
`endif
    case (state_q)
      IDLE: if (found) begin
        state_d = GRANT;
        gnt_d   = N'(1) << win;
        id_d    = win;
        ptr_d   = (win == IDW'(N - 1)) ? '0 : win + 1'b1;
`ifdef ARB_FAIR_EN
        hold_d  = '0;
`endif
      end
      GRANT: if (!own_req) begin
        state_d = RELEASE;
        gnt_d   = '0;
        id_d    = '0;
      end
`ifdef ARB_FAIR_EN
      else if (hold_q == HMAX && |(req & ~gnt_q)) begin
        state_d   = RELEASE;
        gnt_d     = '0;
        id_d      = '0;
        preempt_d = 1'b1;
      end else begin
        hold_d = (hold_q == HMAX) ? hold_q : hold_q + 1'b1;
      end
`endif
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // state registers, cleared asynchronously while rst is low
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      gnt_q   <= '0;
      id_q    <= '0;
`ifdef ARB_FAIR_EN
      hold_q    <= '0;
      preempt_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      id_q    <= id_d;
`ifdef ARB_FAIR_EN
      hold_q    <= hold_d;
      preempt_q <= preempt_d;
`endif
    end
  end
endmodule

// File: doc/req_rr_arb.md
Name: req_rr_arb

Overview:
- Round-robin arbiter that shares one resource among N requesters using a level req/gnt handshake.
- A requester holds req high for as long as it uses the resource and drops req to release it.
- Sits in front of the shared unit that the req/gnt sequence checker monitors.
- Enforces a one-cycle turnaround gap between owners, and can optionally preempt long holders.

Parameters:
- N, 4, number of requesters (2..8).
- IDW, 2, width of gnt_id; must equal clog2(N).
- MAX_HOLD, 8, cycles an owner may hold the grant while others wait (ARB_FAIR_EN only); must be >= 2.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-low reset; rst=0 clears all state immediately
- req  input  N  per-requester level request; bit i is requester i
- gnt  output  N  one-hot grant, registered; all zero when no owner
- gnt_valid  output  1  OR of gnt, registered
- gnt_id  output  IDW  index of current owner; 0 when gnt_valid=0
- busy  output  1  1 in the GRANT and RELEASE states
- preempt  output  1  one-cycle pulse when the owner is forcibly released; constant 0 without ARB_FAIR_EN

Behaviour:
- Reset (rst=0, async):
  - state=IDLE, ptr=0, hold_cnt=0.
  - gnt=0, gnt_valid=0, gnt_id=0, busy=0, preempt=0.
  - Outputs hold these values until the first rising edge after rst returns high.
- State IDLE:
  - If req==0, stay in IDLE.
  - Otherwise the winner is the first set req bit searching ptr, ptr+1, ... N-1, 0, ... (mod N).
  - On that edge: state=GRANT, gnt=one-hot(winner), gnt_id=winner, gnt_valid=1, hold_cnt=0, ptr=(winner+1) mod N.
  - Latency: req sampled high at edge k gives gnt high after edge k.
- State GRANT:
  - If req[gnt_id]==0 at the edge: gnt=0, gnt_valid=0, gnt_id=0, state=RELEASE.
  - Otherwise gnt is held and hold_cnt increments, saturating at MAX_HOLD-1.
  - Changes on other req bits do not disturb the current owner.
- State RELEASE:
  - Lasts exactly one cycle with gnt=0, then state=IDLE.
  - Arbitration resumes in IDLE. Minimum owner-to-owner gap is 2 idle-grant cycles: gnt falls at edge k, the next gnt rises at edge k+2.
- Fairness:
  - ptr advances only on a grant.
  - A continuously requesting requester waits at most N-1 grants.
- Simultaneous events: the owner's req dropping in the same cycle another requester raises req is handled as release first; the new requester is arbitrated in IDLE.
- Invariant: gnt is never multi-hot and never granted to a requester with req=0 at the grant edge.
- Reset mid-grant: gnt drops asynchronously, no RELEASE cycle occurs, and ptr returns to 0.

Optional Feature:
- Macro: ARB_FAIR_EN.
- Defined:
  - In GRANT, if hold_cnt==MAX_HOLD-1, req[gnt_id]==1, and any other req bit is set, the arbiter forcibly releases the owner.
  - On that edge gnt=0, state=RELEASE, and preempt=1 for exactly one cycle.
  - The preempted requester re-competes through normal round-robin.
  - With no other requester pending, the owner keeps the grant indefinitely.
- Undefined:
  - No preemption; hold_cnt is not implemented.
  - preempt is tied to 0.
  - An owner holds gnt until it drops its own req.

Test Plan:
- Reset: rst=0 with req=4'b1111, then release rst -> gnt=0 during reset; gnt=4'b0001, gnt_id=0 one edge after release.
- Round-robin: req=4'b1111 held, each owner drops req for 1 cycle after 3 cycles of grant -> grant order 0,1,2,3,0, with a 2-cycle gap between consecutive gnts.
- Pointer skip: ptr=1, req=4'b1001 -> gnt=4'b1000 (id 3); next arbitration grants id 0.
- Simultaneous release/request: owner 2 drops req in the same cycle req[1] rises -> one RELEASE cycle, then gnt=4'b0010; gnt is never multi-hot.
- Reset mid-grant: rst=0 asserted asynchronously mid-cycle while gnt=4'b0100 -> gnt=0 immediately; after release with req=4'b0100, ptr=0 and gnt=4'b0100 one edge later.
- ARB_FAIR_EN: MAX_HOLD=8, req[0] held and req[1] raised at cycle 2 -> preempt pulses 8 cycles after the grant, then gnt=4'b0010 two edges later; without the macro, gnt stays 4'b0001.
